// File: rtl/count_scheduler_if.sv
// Request/grant/count bundle between a requester pair and count_scheduler.
// master: the requester side (drives req/limit, observes grant/done/count).
// slave:  the scheduler side.
interface count_scheduler_if #(
  parameter int unsigned N = 3
);

  logic         req0;
  logic         req1;
  logic [N-1:0] limit0;
  logic [N-1:0] limit1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic         busy;
  logic [N-1:0] count;

  modport master (
    output req0,
    output req1,
    output limit0,
    output limit1,
    input  gnt0,
    input  gnt1,
    input  done0,
    input  done1,
    input  busy,
    input  count
  );

  modport slave (
    input  req0,
    input  req1,
    input  limit0,
    input  limit1,
    output gnt0,
    output gnt1,
    output done0,
    output done1,
    output busy,
    output count
  );

endinterface

// File: rtl/count_scheduler.sv
// count_scheduler: two requesters share one up-counter. A granted requester
// owns the counter for limit+1 RUN cycles plus one DONE cycle carrying its
// done pulse. Ties are broken round-robin, first tie after reset goes to req0.
// Optional build macro COUNT_SCHED_ABORT_EN: the owner dropping its request
// during RUN abandons the run (back to IDLE, no done pulse).
module count_scheduler #(
  parameter int unsigned N = 3
) (
  input logic              clk,
  input logic              reset,
  count_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         owner_q, owner_d;  // 0: req0 owns the run, 1: req1
  logic         last_q, last_d;    // requester served most recently
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] limit_q, limit_d;

  // Arbitration result, only consumed in IDLE.
  logic         win_valid;
  logic         win;

  // Round-robin pick: a lone request wins outright; a tie goes to the
  // requester not served last. last_q resets to 1 so the first tie picks req0.
  always_comb begin
    win_valid = bus.req0 | bus.req1;
    win       = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = ~last_q;
    end else if (bus.req1) begin
      win = 1'b1;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    limit_d = limit_q;

    unique case (state_q)
      StIdle: begin
        count_d = '0;
        if (win_valid) begin
          state_d = StRun;
          owner_d = win;
          last_d  = win;
          // Limit is captured once here; later changes on limit0/1 are ignored.
          limit_d = win ? bus.limit1 : bus.limit0;
        end
      end

      StRun: begin
`ifdef COUNT_SCHED_ABORT_EN
        // Owner withdrawing its request abandons the run without a done pulse.
        if (!(owner_q ? bus.req1 : bus.req0)) begin
          state_d = StIdle;
          count_d = '0;
        end else if (count_q == limit_q) begin
          state_d = StDone;
        end else begin
          count_d = count_q + N'(1);
        end
`else
        if (count_q == limit_q) begin
          state_d = StDone;
        end else begin
          count_d = count_q + N'(1);
        end
`endif
      end

      StDone: begin
        // Requests are not looked at here; a held request is re-arbitrated
        // from IDLE on the next edge.
        state_d = StIdle;
        count_d = '0;
      end

      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      count_q <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    bus.gnt0  = 1'b0;
    bus.gnt1  = 1'b0;
    bus.done0 = 1'b0;
    bus.done1 = 1'b0;
    bus.busy  = (state_q != StIdle);
    bus.count = count_q;
    if (state_q == StRun || state_q == StDone) begin
      bus.gnt0 = ~owner_q;
      bus.gnt1 = owner_q;
    end
    if (state_q == StDone) begin
      bus.done0 = ~owner_q;
      bus.done1 = owner_q;
    end
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Bench for count_scheduler: directed per-cycle vector table, hand-written
// multi-cycle sequences, then randomized traffic against a run-level model.
module tb_count_scheduler;

  localparam int unsigned N = 3;
  localparam int unsigned W = N + 5;  // {gnt0, gnt1, done0, done1, busy, count}

  logic clk;
  logic reset;

  count_scheduler_if #(.N(N)) bus ();

  count_scheduler #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         rst;
    logic         q0;
    logic         q1;
    logic [N-1:0] l0;
    logic [N-1:0] l1;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Run-level reference model: a run is "cycle k of limit+2" for one owner.
  bit model_en = 1'b0;
  bit m_busy;
  bit m_owner;
  bit m_last;
  int m_k;
  int m_lim;

  function automatic logic [W-1:0] o(input logic g0, input logic g1, input logic d0,
                                     input logic d1, input logic b, input int c);
    logic [N-1:0] cc;
    cc = c[N-1:0];
    return {g0, g1, d0, d1, b, cc};
  endfunction

  function automatic void add(input logic rst, input logic q0, input logic q1, input int l0,
                              input int l1, input logic [W-1:0] exp);
    vec_t v;
    v.rst = rst;
    v.q0  = q0;
    v.q1  = q1;
    v.l0  = l0[N-1:0];
    v.l1  = l1[N-1:0];
    v.exp = exp;
    tbl.push_back(v);
  endfunction

  function automatic logic [W-1:0] outs();
    return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.count};
  endfunction

  function automatic logic [W-1:0] model_out();
    int c;
    if (!m_busy) return '0;
    c = (m_k > m_lim) ? m_lim : m_k;
    return o(!m_owner, m_owner, (m_k == m_lim + 1) && !m_owner, (m_k == m_lim + 1) && m_owner,
             1'b1, c);
  endfunction

  function automatic void model_step(input logic r, input logic q0, input logic q1,
                                     input int l0, input int l1);
    bit w;
    if (!r) begin
      m_busy = 0;
      m_last = 1;
      m_k    = 0;
      return;
    end
    if (!m_busy) begin
      if (q0 || q1) begin
        w       = (q0 && q1) ? !m_last : q1;
        m_busy  = 1;
        m_owner = w;
        m_last  = w;
        m_lim   = w ? l1 : l0;
        m_k     = 0;
      end
    end else if (m_k <= m_lim) begin
`ifdef COUNT_SCHED_ABORT_EN
      if (!(m_owner ? q1 : q0)) m_busy = 0;
      else m_k++;
`else
      m_k++;
`endif
    end else begin
      m_busy = 0;
    end
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got g0g1d0d1b=%b count=%0d, required g0g1d0d1b=%b count=%0d", name,
               act[W-1:N], act[N-1:0], exp[W-1:N], exp[N-1:0]);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, land 1 time unit after it.
  task automatic step(input logic r, input logic q0, input logic q1, input int l0, input int l1);
    reset      = r;
    bus.req0   = q0;
    bus.req1   = q1;
    bus.limit0 = l0[N-1:0];
    bus.limit1 = l1[N-1:0];
    if (model_en) model_step(r, q0, q1, l0, l1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic q0, q1, r;
    reset      = 1'b0;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.limit0 = '0;
    bus.limit1 = '0;
    @(posedge clk);
    #1;

    // Reset state.
    add(0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0));
    // Single requester, limit 4: counts 0..4, done on the sixth cycle.
    add(1, 1, 0, 4, 0, o(1, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 4; k++) add(1, 1, 0, 4, 0, o(1, 0, 0, 0, 1, k));
    add(1, 1, 0, 4, 0, o(1, 0, 1, 0, 1, 4));
    add(1, 0, 0, 4, 0, o(0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 4, 0, o(0, 0, 0, 0, 0, 0));
    // Limit 0 on req1: a single RUN cycle at count 0, then done1.
    add(1, 0, 1, 7, 0, o(0, 1, 0, 0, 1, 0));
    add(1, 0, 1, 7, 0, o(0, 1, 0, 1, 1, 0));
    add(1, 0, 0, 7, 0, o(0, 0, 0, 0, 0, 0));
    // Both held after reset, limit 1: req0, req1, req0 with an IDLE gap.
    add(0, 1, 1, 1, 1, o(0, 0, 0, 0, 0, 0));
    for (int run = 0; run < 3; run++) begin
      logic a0, a1;
      a0 = (run != 1);
      a1 = (run == 1);
      add(1, 1, 1, 1, 1, o(a0, a1, 0, 0, 1, 0));
      add(1, 1, 1, 1, 1, o(a0, a1, 0, 0, 1, 1));
      add(1, 1, 1, 1, 1, o(a0, a1, a0, a1, 1, 1));
      add(1, (run != 2), (run != 2), 1, 1, o(0, 0, 0, 0, 0, 0));
    end

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].q0, tbl[i].q1, tbl[i].l0, tbl[i].l1);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Limit change after grant is ignored.
    step(1, 1, 0, 5, 0);
    check("lim_hold_c0", outs(), o(1, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 0, 1, 0);
      check($sformatf("lim_hold_c%0d", k), outs(), o(1, 0, 0, 0, 1, k));
    end
    step(1, 1, 0, 1, 0);
    check("lim_hold_done", outs(), o(1, 0, 1, 0, 1, 5));
    step(1, 0, 0, 1, 0);
    check("lim_hold_idle", outs(), o(0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-run.
    step(1, 1, 0, 6, 0);
    step(1, 1, 0, 6, 0);
    step(1, 1, 0, 6, 0);
    check("rst_mid_c2", outs(), o(1, 0, 0, 0, 1, 2));
    #2 reset = 1'b0;
    #1;
    check("rst_async", outs(), o(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("rst_held", outs(), o(0, 0, 0, 0, 0, 0));
    step(1, 1, 0, 6, 0);
    check("rst_resume", outs(), o(1, 0, 0, 0, 1, 0));
    step(0, 0, 0, 0, 0);
    check("rst_clean", outs(), o(0, 0, 0, 0, 0, 0));

    // Owner drops its request at count 2 of a limit-6 run.
    step(1, 1, 0, 6, 0);
    step(1, 1, 0, 6, 0);
    step(1, 1, 0, 6, 0);
    check("drop_c2", outs(), o(1, 0, 0, 0, 1, 2));
`ifdef COUNT_SCHED_ABORT_EN
    step(1, 0, 0, 6, 0);
    check("drop_abort", outs(), o(0, 0, 0, 0, 0, 0));
    step(1, 0, 0, 6, 0);
    check("drop_no_done", outs(), o(0, 0, 0, 0, 0, 0));
`else
    for (int k = 3; k <= 6; k++) begin
      step(1, 0, 0, 6, 0);
      check($sformatf("drop_c%0d", k), outs(), o(1, 0, 0, 0, 1, k));
    end
    step(1, 0, 0, 6, 0);
    check("drop_done", outs(), o(1, 0, 1, 0, 1, 6));
    step(1, 0, 0, 6, 0);
    check("drop_idle", outs(), o(0, 0, 0, 0, 0, 0));
`endif

    // Randomized traffic against the model.
    model_en = 1'b1;
    step(0, 0, 0, 0, 0);
    check("rand_reset", outs(), model_out());
    q0 = 0;
    q1 = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) q0 = ~q0;
      if ($urandom_range(0, 3) == 0) q1 = ~q1;
      r = ($urandom_range(0, 79) != 0);
      step(r, q0, q1, $urandom_range(0, 7), $urandom_range(0, 7));
      check($sformatf("rand%0d", i), outs(), model_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_scheduler.md
COUNT_SCHEDULER -- requirements
Module: count_scheduler

Interface
REQ-001 SHALL have parameter N, default 3, the counter and limit width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1  per-requester request for one counting run.
REQ-005 SHALL have ports limit0, limit1  input  N  per-requester terminal count, sampled only at grant.
REQ-006 SHALL have ports gnt0, gnt1  output  1  one-hot grant, high for the whole run of the owner.
REQ-007 SHALL have ports done0, done1  output  1  single-cycle run-complete pulse to the owner.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port count  output  N  current value of the shared counter.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, RUN and DONE; all outputs decode from registered state only.
REQ-011 SHALL, in IDLE with any req high at a clock edge, enter RUN, assert the winner's gnt, capture its limit into limit_reg, and load count=0.
REQ-012 SHALL arbitrate round-robin: with one request, grant it; with both, grant the requester not served last; the first tie after reset grants req0.
REQ-013 SHALL, in RUN, increment count by 1 each cycle while count != limit_reg; count==limit_reg at an edge moves to DONE with count held.
REQ-014 SHALL yield exactly limit_reg+1 RUN cycles; limit_reg=0 gives one RUN cycle at count=0.
REQ-015 SHALL, in DONE, keep gnt high for one cycle, pulse the owner's done for exactly that cycle, then return to IDLE.
REQ-016 SHALL drive count=0 in IDLE, never wrap past limit_reg, and ignore limit0/limit1 changes after grant.
REQ-017 SHALL ignore all req inputs in RUN and DONE (except per REQ-023); a request held through DONE is re-arbitrated in the following IDLE cycle.
REQ-018 SHALL guarantee gnt0 and gnt1 are never both high, and done0 and done1 are never both high.
REQ-019 SHALL update the round-robin pointer to the served requester on entry to RUN.

Reset
REQ-020 SHALL, while reset is low, asynchronously force state IDLE, count=0, limit_reg=0, gnt0=gnt1=0, done0=done1=0, busy=0, round-robin pointer favouring req0.
REQ-021 SHALL, on reset asserted mid-RUN or mid-DONE, abandon the run with no done pulse; operation resumes at the first rising edge after reset goes high.

Configuration
REQ-022 SHALL support macro COUNT_SCHED_ABORT_EN selecting requester-abort behaviour.
REQ-023 SHALL, with COUNT_SCHED_ABORT_EN defined, go from RUN to IDLE on the edge where the owner's req is sampled low; count returns to 0, no done pulse, pointer still records the aborted owner.
REQ-024 SHALL, without COUNT_SCHED_ABORT_EN, complete every granted run regardless of req.

Verification
REQ-025 SHALL cover: req0=1, limit0=4 -> gnt0 high 6 cycles, count 0,1,2,3,4,4, done0 single pulse on 6th cycle, busy low after.
REQ-026 SHALL cover: req0=req1=1 held after reset, limit0=limit1=1 -> grants gnt0, gnt1, gnt0 in turn, one IDLE cycle between runs.
REQ-027 SHALL cover: limit1=0, req1 pulsed -> one RUN cycle at count=0, done1 pulse on following cycle.
REQ-028 SHALL cover: limit0=5 granted, limit0 changed to 1 during run -> run still reaches count=5.
REQ-029 SHALL cover: reset driven low at count=2 of a limit=6 run -> outputs zero immediately, no done pulse, next run starts at count=0.
REQ-030 SHALL cover: req0 dropped at count=2 of limit0=6 -> with COUNT_SCHED_ABORT_EN, IDLE next cycle, no done0; without it, run completes to 6 with done0.
